// File: rtl/redmule_cfg_slave.sv
// RedMulE configuration slave: staging register bank written through a req/gnt
// port, trigger-driven job queue, and a small Idle/Issue/Run handshake FSM
// towards the engine controller.
// Optional build macro: REDMULE_CFG_SLAVE_PERF_EN adds a Run-cycle counter at 0x08.
module redmule_cfg_slave #(
    parameter int unsigned SysDataWidth = 32,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned NumCfgRegs   = 6,
    parameter int unsigned CfgBase      = 'h40,
    parameter int unsigned JobDepth     = 2
) (
    input  logic                               clk_int,
    input  logic                               rst_ni,
    input  logic                               clear_i,
    input  logic                               req_i,
    input  logic                               wen_i,
    input  logic [SysDataWidth/8-1:0]          be_i,
    input  logic [AddrWidth-1:0]               add_i,
    input  logic [SysDataWidth-1:0]            data_i,
    output logic                               gnt_o,
    output logic                               r_valid_o,
    output logic [SysDataWidth-1:0]            r_data_o,
    output logic                               cfg_complete_o,
    output logic                               job_valid_o,
    input  logic                               job_ready_i,
    output logic [NumCfgRegs*SysDataWidth-1:0] job_regs_o,
    input  logic                               engine_done_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o
);

    localparam int unsigned BeW   = SysDataWidth / 8;
    localparam int unsigned PtrW  = (JobDepth > 1) ? $clog2(JobDepth) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned WordW = AddrWidth - 2;
    localparam int unsigned JobW  = NumCfgRegs * SysDataWidth;
    localparam int unsigned IdxW  = (NumCfgRegs > 1) ? $clog2(NumCfgRegs) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [SysDataWidth-1:0] stage_q [NumCfgRegs];
    logic [JobW-1:0]         queue_q [JobDepth];
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    err_q;
    logic                    cfg_complete_q;
    logic                    r_valid_q;
    logic [SysDataWidth-1:0] r_data_q;

    logic [WordW-1:0]        word;
    logic                    is_trig, is_stat, is_perf, is_cfg;
    logic [IdxW-1:0]         cfg_idx;
    logic                    wr_en, rd_en, trig, full, push, pop;
    logic [JobW-1:0]         stage_flat;
    logic [SysDataWidth-1:0] status, rdata;
    logic                    unused_addr_lsb;

    assign unused_addr_lsb = ^add_i[1:0];
    assign word            = add_i[AddrWidth-1:2];

    assign gnt_o = req_i & ~clear_i;
    assign wr_en = gnt_o & ~wen_i;
    assign rd_en = gnt_o & wen_i;
    assign trig  = wr_en & is_trig;
    assign full  = (cnt_q == CntW'(JobDepth));
    assign push  = trig & ~full;
    assign pop   = (state_q == ISSUE) & job_ready_i & ~clear_i;

    // Word-address decode; the low two address bits never matter.
    always_comb begin
        is_trig = (word == '0);
        is_stat = (word == WordW'(1));
        is_perf = (word == WordW'(2));
        is_cfg  = 1'b0;
        cfg_idx = '0;
        for (int k = 0; k < NumCfgRegs; k++) begin
            if (word == WordW'(CfgBase / 4 + k)) begin
                is_cfg  = 1'b1;
                cfg_idx = IdxW'(k);
            end
        end
    end

    // Flatten the staging bank into the job record layout.
    always_comb begin
        stage_flat = '0;
        for (int k = 0; k < NumCfgRegs; k++) begin
            stage_flat[k*SysDataWidth +: SysDataWidth] = stage_q[k];
        end
    end

    // Staging bank: byte-masked writes, zeroed by reset and soft clear.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumCfgRegs; k++) stage_q[k] <= '0;
        end else if (clear_i) begin
            for (int k = 0; k < NumCfgRegs; k++) stage_q[k] <= '0;
        end else if (wr_en && is_cfg) begin
            for (int b = 0; b < BeW; b++) begin
                if (be_i[b]) stage_q[cfg_idx][b*8 +: 8] <= data_i[b*8 +: 8];
            end
        end
    end

    // Job storage is pure data; only the pointers and count need a reset.
    always_ff @(posedge clk_int) begin
        if (push) queue_q[wr_ptr_q] <= stage_flat;
    end

    // Occupancy next state; a push is only possible when not full at cycle start.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Queue pointers, occupancy, sticky overflow error and queue-space flag.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            cfg_complete_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            cfg_complete_q <= (cnt_d != CntW'(JobDepth));
            if (clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                err_q    <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
                if (trig && full) err_q <= 1'b1;
            end
        end
    end

    // FSM next state; soft clear forces Idle regardless of the current state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cnt_q != '0)   state_d = ISSUE;
            ISSUE:   if (job_ready_i)   state_d = RUN;
            RUN:     if (engine_done_i) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    // FSM state register.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

`ifdef REDMULE_CFG_SLAVE_PERF_EN
    logic [31:0] perf_q;

    // Run-cycle counter: restarts when a job is offered, saturates, holds after Run.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (state_q != ISSUE && state_d == ISSUE) begin
            perf_q <= '0;
        end else if (state_q == RUN && perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end
`endif

    // Read multiplexer, evaluated on the granted cycle.
    always_comb begin
        status       = '0;
        status[1:0]  = state_q;
        status[4 +: CntW] = cnt_q;
        status[8]    = err_q;
        rdata        = '0;
        if (is_stat) rdata = status;
        if (is_cfg)  rdata = stage_q[cfg_idx];
`ifdef REDMULE_CFG_SLAVE_PERF_EN
        if (is_perf) rdata = SysDataWidth'(perf_q);
`else
        if (is_perf) rdata = '0;
`endif
    end

    // Response channel: one r_valid per grant, read data captured at grant time.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= gnt_o;
            if (gnt_o) r_data_q <= rd_en ? rdata : '0;
        end
    end

    assign r_valid_o      = r_valid_q & ~clear_i;
    assign r_data_o       = r_data_q;
    assign cfg_complete_o = cfg_complete_q;
    assign job_valid_o    = (state_q == ISSUE);
    assign job_regs_o     = (state_q == ISSUE) ? queue_q[rd_ptr_q] : '0;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == RUN) & engine_done_i & ~clear_i;
    assign err_o          = err_q;

endmodule

// File: tb/tb_redmule_cfg_slave.sv
// Self-checking bench for redmule_cfg_slave: register-access vector table,
// directed job-flow sequences and randomized traffic against a queue-based model.
module tb_redmule_cfg_slave;

    logic         clk_int = 1'b0;
    logic         rst_ni = 1'b0;
    logic         clear_i = 1'b0;
    logic         req_i = 1'b0;
    logic         wen_i = 1'b0;
    logic [3:0]   be_i = '0;
    logic [31:0]  add_i = '0;
    logic [31:0]  data_i = '0;
    logic         job_ready_i = 1'b0;
    logic         engine_done_i = 1'b0;
    logic         gnt_o, r_valid_o, cfg_complete_o, job_valid_o, busy_o, done_o, err_o;
    logic [31:0]  r_data_o;
    logic [191:0] job_regs_o;

    int checks = 0;
    int failures = 0;
    int ndone = 0;

    // Reference model state
    logic [31:0]  m_stage [6];
    logic [191:0] m_q [$];
    int           m_state;      // 0 Idle, 1 Issue, 2 Run
    bit           m_err, m_rv, m_cc;
    logic [31:0]  m_rd, m_perf;

    redmule_cfg_slave dut (
        .clk_int(clk_int), .rst_ni(rst_ni), .clear_i(clear_i),
        .req_i(req_i), .wen_i(wen_i), .be_i(be_i), .add_i(add_i), .data_i(data_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_data_o(r_data_o),
        .cfg_complete_o(cfg_complete_o), .job_valid_o(job_valid_o),
        .job_ready_i(job_ready_i), .job_regs_o(job_regs_o),
        .engine_done_i(engine_done_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_int = ~clk_int;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 6; k++) m_stage[k] = '0;
        m_q.delete();
        m_state = 0; m_err = 0; m_rv = 0; m_cc = 0; m_rd = '0; m_perf = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] v;
        int w;
        v = '0;
        w = int'(a >> 2);
        if (w == 1) begin
            v[8] = m_err;
            v[7:4] = 4'(m_q.size());
            v[1:0] = 2'(m_state);
        end else if (w == 2) begin
`ifdef REDMULE_CFG_SLAVE_PERF_EN
            v = m_perf;
`else
            v = '0;
`endif
        end else if (w >= 16 && w < 22) begin
            v = m_stage[w-16];
        end
        return v;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic m_step();
        int sz0, st0, st1, w;
        bit do_push;
        logic [191:0] job;
        sz0 = m_q.size(); st0 = m_state; st1 = st0; do_push = 0; job = '0;
        if (clear_i) begin
            for (int k = 0; k < 6; k++) m_stage[k] = '0;
            m_q.delete();
            m_err = 0; m_rv = 0; st1 = 0;
        end else begin
            m_rv = req_i;
            if (req_i) m_rd = wen_i ? m_read(add_i) : 32'h0;
            if (req_i && !wen_i) begin
                w = int'(add_i >> 2);
                if (w == 0) begin
                    if (sz0 == 2) m_err = 1;
                    else begin
                        do_push = 1;
                        for (int k = 0; k < 6; k++) job[k*32 +: 32] = m_stage[k];
                    end
                end else if (w >= 16 && w < 22) begin
                    for (int b = 0; b < 4; b++)
                        if (be_i[b]) m_stage[w-16][b*8 +: 8] = data_i[b*8 +: 8];
                end
            end
            if (st0 == 1 && job_ready_i) begin
                void'(m_q.pop_front());
                st1 = 2;
            end else if (st0 == 0 && sz0 > 0) st1 = 1;
            else if (st0 == 2 && engine_done_i) st1 = 0;
            if (do_push) m_q.push_back(job);
        end
        m_cc = (m_q.size() < 2);
        if (st1 == 1 && st0 != 1) m_perf = '0;
        else if (st0 == 2 && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
        m_state = st1;
    endtask

    // Compare every output with the model mid-cycle, then clock DUT and model.
    task automatic tick();
        #1;
        chk("gnt", gnt_o, req_i & ~clear_i);
        chk("r_valid", r_valid_o, m_rv & ~clear_i);
        chk("r_data", r_data_o, m_rd);
        chk("cfg_complete", cfg_complete_o, m_cc);
        chk("job_valid", job_valid_o, m_state == 1);
        chk("job_regs", job_regs_o, (m_state == 1) ? m_q[0] : 192'h0);
        chk("busy", busy_o, m_state != 0);
        chk("done", done_o, (m_state == 2) && engine_done_i && !clear_i);
        chk("err", err_o, m_err);
        if (done_o) ndone++;
        @(posedge clk_int);
        m_step();
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req_i = 1; wen_i = 0; add_i = a; data_i = d; be_i = b;
        tick();
        req_i = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        req_i = 1; wen_i = 1; add_i = a;
        tick();
        req_i = 0; wen_i = 0;
        v = r_data_o;
        chk("rd_valid", r_valid_o, 1'b1);
    endtask

    typedef struct {
        logic        wen;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t        vt [12];
        logic [31:0] alist [12];
        logic [31:0] v;
        int          nd0;
        logic [31:0] perf_exp;

        vt[0]  = '{1'b0, 4'hF,    32'h44, 32'h0000_0000, 32'h0};
        vt[1]  = '{1'b0, 4'b0101, 32'h44, 32'hAABB_CCDD, 32'h0};
        vt[2]  = '{1'b1, 4'h0,    32'h44, 32'h0,         32'h00BB_00DD};
        vt[3]  = '{1'b0, 4'b1000, 32'h48, 32'h1234_5678, 32'h0};
        vt[4]  = '{1'b1, 4'h0,    32'h48, 32'h0,         32'h1200_0000};
        vt[5]  = '{1'b0, 4'hF,    32'h43, 32'hCAFE_F00D, 32'h0};
        vt[6]  = '{1'b1, 4'h0,    32'h40, 32'h0,         32'hCAFE_F00D};
        vt[7]  = '{1'b0, 4'hF,    32'h0C, 32'hDEAD_BEEF, 32'h0};
        vt[8]  = '{1'b1, 4'h0,    32'h0C, 32'h0,         32'h0};
        vt[9]  = '{1'b1, 4'h0,    32'h58, 32'h0,         32'h0};
        vt[10] = '{1'b0, 4'hF,    32'h04, 32'hFFFF_FFFF, 32'h0};
        vt[11] = '{1'b1, 4'h0,    32'h05, 32'h0,         32'h0};
        alist = '{32'h00, 32'h04, 32'h08, 32'h40, 32'h44, 32'h48,
                  32'h4C, 32'h50, 32'h54, 32'h0C, 32'h58, 32'h3C};
`ifdef REDMULE_CFG_SLAVE_PERF_EN
        perf_exp = 32'd10;
`else
        perf_exp = 32'd0;
`endif

        // Reset state
        m_reset();
        #3;
        chk("rst_cfg_complete", cfg_complete_o, 1'b0);
        chk("rst_job_valid", job_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_r_valid", r_valid_o, 1'b0);
        chk("rst_job_regs", job_regs_o, 192'h0);
        @(posedge clk_int); @(posedge clk_int); #1;
        rst_ni = 1;
        tick();
        chk("cfg_complete_after_rst", cfg_complete_o, 1'b1);

        // Register access table
        for (int i = 0; i < 12; i++) begin
            req_i = 1; wen_i = vt[i].wen; be_i = vt[i].be; add_i = vt[i].addr; data_i = vt[i].data;
            tick();
            req_i = 0;
            chk($sformatf("vec%0d_r_valid", i), r_valid_o, 1'b1);
            chk($sformatf("vec%0d_r_data", i), r_data_o, vt[i].exp_rdata);
        end
        tick();
        chk("no_r_valid_without_req", r_valid_o, 1'b0);

        // Fill bank and trigger one job
        for (int k = 0; k < 6; k++) wr(32'h40 + 4*k, 32'h11 * (k + 1), 4'hF);
        wr(32'h00, 32'h0, 4'h0);
        chk("trig_cfg_complete", cfg_complete_o, 1'b1);
        chk("job_valid_T1", job_valid_o, 1'b0);
        tick();
        chk("job_valid_T2", job_valid_o, 1'b1);
        chk("job_reg0", job_regs_o[31:0], 32'h11);
        chk("job_reg5", job_regs_o[191:160], 32'h66);
        tick();
        chk("job_held", job_regs_o[191:160], 32'h66);

        // Accept, run 10 cycles, done
        job_ready_i = 1; tick(); job_ready_i = 0;
        nd0 = ndone;
        for (int i = 0; i < 9; i++) begin
            chk("busy_run", busy_o, 1'b1);
            tick();
        end
        chk("busy_run10", busy_o, 1'b1);
        engine_done_i = 1; #1;
        chk("done_pulse", done_o, 1'b1);
        tick();
        engine_done_i = 0;
        chk("done_count", ndone - nd0, 1);
        chk("busy_after_done", busy_o, 1'b0);
        rd(32'h08, v);
        chk("perf", v, perf_exp);

        // Overflow with engine stalled
        wr(32'h00, 0, 0); wr(32'h00, 0, 0); wr(32'h00, 0, 0);
        chk("ovf_cfg_complete", cfg_complete_o, 1'b0);
        chk("ovf_err", err_o, 1'b1);
        rd(32'h04, v);
        chk("ovf_status", v, 32'h121);

        // Trigger during pop of a full queue
        clear_i = 1; tick(); clear_i = 0;
        chk("clr_err", err_o, 1'b0);
        wr(32'h00, 0, 0); wr(32'h00, 0, 0);
        chk("full_issue", job_valid_o, 1'b1);
        chk("full_err0", err_o, 1'b0);
        job_ready_i = 1; wr(32'h00, 0, 0); job_ready_i = 0;
        chk("pop_trig_err", err_o, 1'b1);
        rd(32'h04, v);
        chk("pop_trig_status", v, 32'h112);

        // Clear during Run with one job queued
        clear_i = 1; req_i = 1; wen_i = 1; add_i = 32'h04; engine_done_i = 1; #1;
        chk("clr_gnt", gnt_o, 1'b0);
        chk("clr_done", done_o, 1'b0);
        tick();
        clear_i = 0; req_i = 0; wen_i = 0; engine_done_i = 0;
        chk("clr_busy", busy_o, 1'b0);
        chk("clr_err2", err_o, 1'b0);
        chk("clr_cfg_complete", cfg_complete_o, 1'b1);
        rd(32'h04, v);
        chk("clr_status", v, 32'h0);
        rd(32'h40, v);
        chk("clr_stage", v, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            req_i = ($urandom_range(0, 1) == 1);
            wen_i = ($urandom_range(0, 2) == 0);
            add_i = alist[$urandom_range(0, 11)] | 32'($urandom_range(0, 3));
            be_i = 4'($urandom);
            data_i = $urandom;
            job_ready_i = ($urandom_range(0, 3) == 0);
            engine_done_i = ($urandom_range(0, 4) == 0);
            clear_i = ($urandom_range(0, 49) == 0);
            tick();
        end
        req_i = 0; job_ready_i = 0; engine_done_i = 0; clear_i = 0;

        // Reset in the middle of a job
        wr(32'h00, 0, 0); tick();
        job_ready_i = 1; tick(); job_ready_i = 0;
        chk("pre_rst_busy", busy_o, 1'b1);
        engine_done_i = 1;
        rst_ni = 0; #1;
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_done", done_o, 1'b0);
        chk("mid_rst_cfg_complete", cfg_complete_o, 1'b0);
        m_reset();
        @(posedge clk_int); #1;
        rst_ni = 1; engine_done_i = 0;
        tick();
        rd(32'h04, v);
        chk("post_rst_status", v, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
